// File: rtl/riscvy_pkg.sv
// Shared types for the data-memory port arbiter.
// Holds the FSM state and owner enums plus a counter-width helper.
package riscvy_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_AUX
    } arb_owner_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of core grants made while aux was waiting.
// at_max forces the next arbitration in favour of aux.
module dmem_arb_starve_ctr
    import riscvy_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned W = cnt_w(MAX + 1);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port (core vs aux).
// Optional DMEM_ARB_PERF_EN adds wait/grant/forced performance counters.
module dmem_port_arbiter
    import riscvy_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_done,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,output logic [31:0]       perf_core_wait
   ,output logic [31:0]       perf_aux_grants
   ,output logic [15:0]       perf_forced
`endif
);

    localparam int unsigned LAT_W = cnt_w(MEM_LAT);

    arb_state_e        state;
    arb_state_e        state_nx;
    arb_owner_e        owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              grant_core;
    logic              grant_aux;
    logic              at_max;
    logic              force_aux;
    logic              last_beat;
    logic              in_access;
    logic              in_idle;

    assign in_access = (state == ARB_ACCESS);
    assign in_idle   = (state == ARB_IDLE);
    assign force_aux = aux_req & at_max;
    assign last_beat = (lat_cnt == LAT_W'(MEM_LAT - 1));

    dmem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_core & aux_req),
        .clr    (grant_aux | (in_idle & ~aux_req)),
        .at_max (at_max)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arbitration and sequencing: core first unless aux is starved.
    always_comb begin
        state_nx   = state;
        grant_core = 1'b0;
        grant_aux  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (core_req && !force_aux) begin
                    grant_core = 1'b1;
                    state_nx   = ARB_ACCESS;
                end else if (aux_req) begin
                    grant_aux = 1'b1;
                    state_nx  = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (last_beat) begin
                    state_nx = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_nx = ARB_IDLE;
            end
            default: begin
                state_nx = ARB_IDLE;
            end
        endcase
    end

    // Latency counter runs only while the strobe is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt <= '0;
        end else if (in_access && !last_beat) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
        end else begin
            lat_cnt <= '0;
        end
    end

    // Capture the winner's request so it may drop req without effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= OWN_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_core) begin
            owner   <= OWN_CORE;
            we_q    <= core_we;
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
        end else if (grant_aux) begin
            owner   <= OWN_AUX;
            we_q    <= aux_we;
            addr_q  <= aux_addr;
            wdata_q <= aux_wdata;
        end
    end

    // Read data lands in the owner's register on the last access beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rdata <= '0;
            aux_rdata  <= '0;
        end else if (in_access && last_beat && !we_q) begin
            if (owner == OWN_CORE) begin
                core_rdata <= mem_rdata;
            end else begin
                aux_rdata <= mem_rdata;
            end
        end
    end

    assign mem_read   = in_access & ~we_q;
    assign mem_write  = in_access & we_q;
    assign mem_addr   = in_access ? addr_q : '0;
    assign mem_wdata  = in_access ? wdata_q : '0;
    assign core_done  = (state == ARB_RESP) && (owner == OWN_CORE);
    assign aux_done   = (state == ARB_RESP) && (owner == OWN_AUX);
    assign core_stall = core_req & ~core_done;

`ifdef DMEM_ARB_PERF_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_core_wait  <= '0;
            perf_aux_grants <= '0;
            perf_forced     <= '0;
        end else begin
            perf_core_wait  <= perf_core_wait + 32'(core_stall);
            perf_aux_grants <= perf_aux_grants + 32'(grant_aux);
            perf_forced     <= perf_forced + 16'(grant_aux & core_req & at_max);
        end
    end
`endif

endmodule
